// File: rtl/shift_issue_stage.sv
// rtl/shift_issue_stage.sv - decode R-type shift instructions and issue shifter operands via a 2-entry skid buffer
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   flush        synchronous flush, drops all buffered entries
//   in_valid     instruction/operands valid
//   in_ready     stage can accept (registered)
//   in_instr     raw instruction word
//   in_rs_val    GPR[rs], low AW bits are the variable shift amount
//   in_rt_val    GPR[rt], value to shift
//   out_valid    operands valid toward shifter
//   out_ready    downstream accepts
//   out_data     shifter data_in
//   out_opsel    shifter bs_opsel {arith,leftright,logicrot}
//   out_amount   shifter shift_amount
//   out_rd       destination register instr[15:11]
//   out_illegal  instruction is not a supported shift
module shift_issue_stage #(
    parameter int REGS_WIDTH = 32,
    parameter int TAG_W      = 5,
    localparam int AW        = $clog2(REGS_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [REGS_WIDTH-1:0] in_rs_val,
    input  logic [REGS_WIDTH-1:0] in_rt_val,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REGS_WIDTH-1:0] out_data,
    output logic [2:0]            out_opsel,
    output logic [AW-1:0]         out_amount,
    output logic [TAG_W-1:0]      out_rd,
    output logic                  out_illegal
);

    localparam int SW = (AW > 5) ? AW : 5;
    localparam int PW = REGS_WIDTH + 3 + AW + TAG_W + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_main;
    logic [PW-1:0]   r_skid;
    logic            r_in_ready;
    logic            r_out_valid;

    logic [5:0]      w_opcode;
    logic [5:0]      w_funct;
    logic [SW-1:0]   w_shamt_ext;
    logic [AW-1:0]   w_shamt;
    logic [AW-1:0]   w_var_amt;
    logic [2:0]      w_opsel;
    logic [AW-1:0]   w_amount;
    logic            w_illegal;
    logic [TAG_W-1:0] w_rd;
    logic [PW-1:0]   w_payload;
    logic            w_accept;
    logic            w_pop;
    logic            w_unused_bits;

    assign w_opcode    = in_instr[31:26];
    assign w_funct     = in_instr[5:0];
    assign w_shamt_ext = SW'(in_instr[10:6]);
    assign w_shamt     = w_shamt_ext[AW-1:0];
    assign w_var_amt   = in_rs_val[AW-1:0];
    assign w_rd        = TAG_W'(in_instr[15:11]);

    assign w_unused_bits = ^{in_instr[25:22], in_instr[20:16], in_rs_val[REGS_WIDTH-1:AW]};

    always_comb begin
        w_opsel   = 3'b000;
        w_amount  = '0;
        w_illegal = 1'b0;
        if (w_opcode != 6'd0) begin
            w_illegal = 1'b1;
        end else begin
            case (w_funct)
                6'b000000: begin
                    w_opsel  = 3'b000;
                    w_amount = w_shamt;
                end
                6'b000010: begin
                    // r2 ROTR reuses the SRL funct, distinguished by the rs-field LSB
                    w_opsel  = in_instr[21] ? 3'b011 : 3'b010;
                    w_amount = w_shamt;
                end
                6'b000011: begin
                    w_opsel  = 3'b110;
                    w_amount = w_shamt;
                end
                6'b000100: begin
                    w_opsel  = 3'b000;
                    w_amount = w_var_amt;
                end
                6'b000110: begin
                    // r2 ROTRV reuses the SRLV funct, distinguished by the shamt-field LSB
                    w_opsel  = in_instr[6] ? 3'b011 : 3'b010;
                    w_amount = w_var_amt;
                end
                6'b000111: begin
                    w_opsel  = 3'b110;
                    w_amount = w_var_amt;
                end
                default: begin
                    w_illegal = 1'b1;
                end
            endcase
        end
    end

    assign w_payload = {in_rt_val, w_opsel, w_amount, w_rd, w_illegal};

    // in_ready is registered, so it already reflects "skid slot free"
    assign w_accept = in_valid && r_in_ready;
    assign w_pop    = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main      <= w_payload;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_pop) begin
                        r_skid     <= w_payload;
                        r_state    <= ST_TWO;
                        r_in_ready <= 1'b0;
                    end else if (w_pop && !w_accept) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end else if (w_pop && w_accept) begin
                        r_main <= w_payload;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        r_main     <= r_skid;
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign {out_data, out_opsel, out_amount, out_rd, out_illegal} = r_main;

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb/tb_shift_issue_stage.sv - self-checking bench for shift_issue_stage against a queue-based reference model
module tb_shift_issue_stage;

    localparam int RW = 32;
    localparam int TW = 5;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_instr = '0;
    logic [RW-1:0] in_rs_val = '0;
    logic [RW-1:0] in_rt_val = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] out_data;
    logic [2:0]    out_opsel;
    logic [AW-1:0] out_amount;
    logic [TW-1:0] out_rd;
    logic          out_illegal;

    shift_issue_stage #(.REGS_WIDTH(RW), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_opsel(out_opsel), .out_amount(out_amount),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] data;
        logic [2:0]    opsel;
        logic [AW-1:0] amount;
        logic [TW-1:0] rd;
        logic          illegal;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_emitted = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int rs, input int rt,
                                       input int rd, input int sh, input int fn);
        logic [31:0] w;
        w = {op[5:0], rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
        return w;
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [RW-1:0] rs,
                                        input logic [RW-1:0] rt);
        exp_t e;
        int   fn;
        int   shamt;
        int   varamt;
        fn     = int'(ins[5:0]);
        shamt  = int'(ins[10:6]) % RW;
        varamt = int'(rs % RW);
        e.data    = rt;
        e.rd      = ins[15:11];
        e.illegal = 1'b0;
        e.opsel   = 3'b000;
        e.amount  = '0;
        if (ins[31:26] != 0 || !(fn inside {0, 2, 3, 4, 6, 7})) begin
            e.illegal = 1'b1;
        end else begin
            // arith bit set for SRA/SRAV, leftright bit for every right shift, logicrot for rotates
            if (fn == 3 || fn == 7) e.opsel = 3'b110;
            else if (fn == 2)       e.opsel = ins[21] ? 3'b011 : 3'b010;
            else if (fn == 6)       e.opsel = ins[6] ? 3'b011 : 3'b010;
            else                    e.opsel = 3'b000;
            e.amount = AW'((fn >= 4) ? varamt : shamt);
        end
        return e;
    endfunction

    // One clock: predict from the model, advance the model, then compare the DUT #1 after the edge.
    task automatic step();
        bit   acc;
        bit   pop;
        bit   was_reset;
        exp_t e;
        acc = in_valid && (q.size() < 2);
        pop = (q.size() > 0) && out_ready;
        e = ref_decode(in_instr, in_rs_val, in_rt_val);
        was_reset = !rst_n;
        @(posedge clk);
        #1;
        if (!rst_n && was_reset) q.delete();
        else if (flush) q.delete();
        else begin
            if (pop) begin
                void'(q.pop_front());
                n_emitted++;
            end
            if (acc) q.push_back(e);
        end
        if (was_reset) begin
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd1);
            check("rst_payload", 64'({out_data, out_opsel, out_amount, out_rd, out_illegal}), 64'd0);
        end else begin
            check("out_valid", 64'(out_valid), 64'(q.size() > 0));
            check("in_ready", 64'(in_ready), 64'(q.size() < 2));
            if (q.size() > 0) begin
                check("data", 64'(out_data), 64'(q[0].data));
                check("opsel", 64'(out_opsel), 64'(q[0].opsel));
                check("amount", 64'(out_amount), 64'(q[0].amount));
                check("rd", 64'(out_rd), 64'(q[0].rd));
                check("illegal", 64'(out_illegal), 64'(q[0].illegal));
            end
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input logic [RW-1:0] rs,
                         input logic [RW-1:0] rt);
        in_valid  = v;
        in_instr  = ins;
        in_rs_val = rs;
        in_rt_val = rt;
    endtask

    initial begin
        // reset
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;

        // SLL rt=1 shamt=4
        drive(1, mk(0, 0, 2, 9, 4, 0), 32'h0, 32'h1);
        step();
        check("sll_valid", 64'(out_valid), 64'd1);
        check("sll_data", 64'(out_data), 64'd1);
        check("sll_opsel", 64'(out_opsel), 64'd0);
        check("sll_amt", 64'(out_amount), 64'd4);

        // SRAV rs=0x23 truncates to 3
        drive(1, mk(0, 1, 2, 17, 0, 7), 32'h23, 32'h8000_0000);
        step();
        check("srav_opsel", 64'(out_opsel), 64'b110);
        check("srav_amt", 64'(out_amount), 64'd3);
        check("srav_rd", 64'(out_rd), 64'd17);

        // ROTR vs SRL
        drive(1, mk(0, 1, 2, 3, 8, 2), 32'h0, 32'hDEAD_BEEF);
        step();
        check("rotr_opsel", 64'(out_opsel), 64'b011);
        check("rotr_amt", 64'(out_amount), 64'd8);
        drive(1, mk(0, 0, 2, 3, 8, 2), 32'h0, 32'hDEAD_BEEF);
        step();
        check("srl_opsel", 64'(out_opsel), 64'b010);

        // ROTRV: instr[6]=1 via shamt field LSB
        drive(1, mk(0, 1, 2, 3, 1, 6), 32'h7F, 32'h1234);
        step();
        check("rotrv_opsel", 64'(out_opsel), 64'b011);
        check("rotrv_amt", 64'(out_amount), 64'd31);

        // drain, then stall with 3 back-to-back inputs
        drive(0, 32'h0, 32'h0, 32'h0);
        step();
        out_ready = 1'b0;
        drive(1, mk(0, 0, 1, 1, 1, 0), 32'h0, 32'hA1);
        step();
        drive(1, mk(0, 0, 1, 2, 2, 0), 32'h0, 32'hA2);
        step();
        check("stall_in_ready_lo", 64'(in_ready), 64'd0);
        drive(1, mk(0, 0, 1, 3, 3, 0), 32'h0, 32'hA3);
        step();
        check("stall_hold_data", 64'(out_data), 64'hA1);
        drive(0, 32'h0, 32'h0, 32'h0);
        out_ready = 1'b1;
        step();
        check("stall_pop1_data", 64'(out_data), 64'hA2);
        check("stall_in_ready_hi", 64'(in_ready), 64'd1);
        step();
        check("stall_drained", 64'(out_valid), 64'd0);

        // illegal encodings
        drive(1, mk(8, 1, 2, 3, 5, 2), 32'h0, 32'h55);
        step();
        check("addi_illegal", 64'(out_illegal), 64'd1);
        check("addi_opsel", 64'(out_opsel), 64'd0);
        check("addi_amt", 64'(out_amount), 64'd0);
        drive(1, mk(0, 1, 2, 3, 5, 1), 32'h0, 32'h55);
        step();
        check("funct1_illegal", 64'(out_illegal), 64'd1);

        // fill TWO then flush with in_valid
        out_ready = 1'b0;
        drive(1, mk(0, 0, 1, 4, 4, 3), 32'h0, 32'hB1);
        step();
        drive(1, mk(0, 0, 1, 5, 5, 3), 32'h0, 32'hB2);
        step();
        check("two_in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        drive(1, mk(0, 0, 1, 6, 6, 3), 32'h0, 32'hB3);
        step();
        flush = 1'b0;
        drive(0, 32'h0, 32'h0, 32'h0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        check("flush_nothing", 64'(out_valid), 64'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int          sel;
            logic [31:0] ins;
            ins = $urandom();
            sel = $urandom_range(0, 9);
            if (sel < 8) begin
                ins[31:26] = 6'd0;
                if (sel < 6) ins[5:0] = 6'(sel == 0 ? 0 : sel == 1 ? 2 : sel == 2 ? 3 :
                                           sel == 3 ? 4 : sel == 4 ? 6 : 7);
            end
            drive($urandom_range(0, 3) != 0, ins, $urandom(), $urandom());
            out_ready = $urandom_range(0, 2) != 0;
            flush = ($urandom_range(0, 49) == 0);
            rst_n = ($urandom_range(0, 149) != 0);
            step();
        end
        flush = 1'b0;
        rst_n = 1'b1;

        // reset mid-stream
        out_ready = 1'b0;
        drive(1, mk(0, 0, 1, 7, 7, 0), 32'h0, 32'hC1);
        step();
        drive(1, mk(0, 0, 1, 8, 8, 0), 32'h0, 32'hC2);
        step();
        rst_n = 1'b0;
        step();
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        drive(0, 32'h0, 32'h0, 32'h0);
        step();

        check("emitted_some", 64'(n_emitted > 50), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
